mitm_out_shifter: RTL and testbench

//  Output-side counterpart of the MITM decision logic. Accepts one word per handshake
//  (fake data + fake-select) and serialises it onto one intercepted SPI data line
//  (MISO or MOSI; one instance per line), phase-locked to the real bus SCLK/CS_n.

---
 rtl/mitm_out_shifter_pkg.sv | 12 +
 rtl/mitm_edge_sync.sv | 39 +++
 rtl/mitm_out_shifter.sv | 179 +++++++++++++++++
 tb/tb_mitm_out_shifter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mitm_out_shifter_pkg.sv
// Shared definitions for the MITM output shifter slice.
package mitm_out_shifter_pkg;

  // Two-state shifter FSM, encodings shared with the other mitm_* blocks.
  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StShift = 1'b1
  } mitm_state_e;

  localparam int unsigned DefaultDataSize = 8;

endpackage

// File: rtl/mitm_edge_sync.sv
// Multi-stage synchroniser for an asynchronous bus pin with rise/fall pulse detect.
module mitm_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  // Shift the pin through the synchroniser and remember the last synchronised level.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sig_i};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Reset to the idle bus level so no spurious edge is seen after reset.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  // Single-cycle edge pulses on the synchronised level.
  always_comb begin
    rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
    fall_o = ~sync_q[SYNC_STAGES-1] & prev_q;
  end

endmodule

// File: rtl/mitm_out_shifter.sv
// Serialises queued fake words onto one intercepted SPI data line, locked to the real bus.
module mitm_out_shifter
  import mitm_out_shifter_pkg::*;
#(
  parameter int unsigned DATA_SIZE   = DefaultDataSize,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CPOL        = 0,
  parameter int unsigned MSB_FIRST   = 1,
  localparam int unsigned CntW       = $clog2(DATA_SIZE + 1)
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 bus_sclk_in,
  input  logic                 bus_cs_n_in,
  input  logic                 real_bit_in,
  input  logic                 load_valid,
  input  logic [DATA_SIZE-1:0] load_data,
  input  logic                 load_select,
  output logic                 load_ready,
  output logic                 bus_bit_out,
  output logic [CntW-1:0]      bit_count,
  output logic                 word_done,
  output logic                 underrun,
  output logic                 frame_abort
);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic lead, trail;

  mitm_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (CPOL != 0)
  ) u_sclk_sync (
    .sys_clk(sys_clk),
    .rst    (rst),
    .sig_i  (bus_sclk_in),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  mitm_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (1'b1)
  ) u_cs_sync (
    .sys_clk(sys_clk),
    .rst    (rst),
    .sig_i  (bus_cs_n_in),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  assign lead  = (CPOL == 0) ? sclk_rise : sclk_fall;
  assign trail = (CPOL == 0) ? sclk_fall : sclk_rise;

  mitm_state_e          state_q, state_d;
  logic                 hold_full_q, hold_full_d;
  logic [DATA_SIZE-1:0] hold_data_q, hold_data_d;
  logic                 hold_sel_q, hold_sel_d;
  logic [DATA_SIZE-1:0] shift_q, shift_d;
  logic                 act_sel_q, act_sel_d;
  logic [CntW-1:0]      bit_count_q, bit_count_d;
  logic                 start_pend_q, start_pend_d;
  logic                 word_done_q, word_done_d;
  logic                 underrun_q, underrun_d;
  logic                 frame_abort_q, frame_abort_d;

  logic                 in_shift, word_start, load_fire, last_lead, cur_bit;
  logic [DATA_SIZE-1:0] shift_adv;

  // FSM state register.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // FSM next state: a frame spans CS_n low.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (cs_fall) state_d = StShift;
      StShift: if (cs_rise) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign in_shift   = (state_q == StShift);
  // Back-to-back words start the cycle after the final lead edge, unless CS_n is rising.
  assign word_start = (!in_shift && cs_fall) || (in_shift && start_pend_q && !cs_rise);
  assign load_fire  = load_valid && !hold_full_q;
  assign last_lead  = (bit_count_q == CntW'(DATA_SIZE - 1));
  assign shift_adv  = (MSB_FIRST != 0) ? {shift_q[DATA_SIZE-2:0], 1'b0}
                                       : {1'b0, shift_q[DATA_SIZE-1:1]};
  assign cur_bit    = (MSB_FIRST != 0) ? shift_q[DATA_SIZE-1] : shift_q[0];

  // Datapath next state: hold/shift registers, bit counter and status pulses.
  always_comb begin
    hold_full_d   = hold_full_q;
    hold_data_d   = hold_data_q;
    hold_sel_d    = hold_sel_q;
    shift_d       = shift_q;
    act_sel_d     = act_sel_q;
    bit_count_d   = bit_count_q;
    start_pend_d  = 1'b0;
    word_done_d   = 1'b0;
    underrun_d    = 1'b0;
    frame_abort_d = 1'b0;

    if (in_shift && cs_rise) begin
      // Frame end: drop the partial word but keep any queued word for the next frame.
      frame_abort_d = (bit_count_q != '0);
      bit_count_d   = '0;
      act_sel_d     = 1'b0;
    end else begin
      if (word_start) begin
        shift_d     = hold_full_q ? hold_data_q : '0;
        act_sel_d   = hold_full_q && hold_sel_q;
        underrun_d  = !hold_full_q;
        hold_full_d = 1'b0;
      end
      if (in_shift && lead) begin
        if (last_lead) begin
          bit_count_d  = '0;
          word_done_d  = 1'b1;
          start_pend_d = 1'b1;
        end else begin
          bit_count_d = bit_count_q + 1'b1;
        end
      end else if (in_shift && trail && (bit_count_q != '0)) begin
        // A zero count means the next word is already loaded; do not shift it.
        shift_d = shift_adv;
      end
    end

    // Evaluated after word start so a word accepted now waits for the next word.
    if (load_fire) begin
      hold_full_d = 1'b1;
      hold_data_d = load_data;
      hold_sel_d  = load_select;
    end
  end

  // Datapath registers.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      hold_full_q   <= 1'b0;
      hold_data_q   <= '0;
      hold_sel_q    <= 1'b0;
      shift_q       <= '0;
      act_sel_q     <= 1'b0;
      bit_count_q   <= '0;
      start_pend_q  <= 1'b0;
      word_done_q   <= 1'b0;
      underrun_q    <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      hold_full_q   <= hold_full_d;
      hold_data_q   <= hold_data_d;
      hold_sel_q    <= hold_sel_d;
      shift_q       <= shift_d;
      act_sel_q     <= act_sel_d;
      bit_count_q   <= bit_count_d;
      start_pend_q  <= start_pend_d;
      word_done_q   <= word_done_d;
      underrun_q    <= underrun_d;
      frame_abort_q <= frame_abort_d;
    end
  end

  // Outputs: real line passes through combinationally unless a fake word is active.
  always_comb begin
    bus_bit_out = (in_shift && act_sel_q) ? cur_bit : real_bit_in;
    load_ready  = !hold_full_q;
    bit_count   = bit_count_q;
    word_done   = word_done_q;
    underrun    = underrun_q;
    frame_abort = frame_abort_q;
  end

endmodule

// File: tb/tb_mitm_out_shifter.sv
// Directed bench for mitm_out_shifter: table of single-word frames plus corner sequences.
module tb_mitm_out_shifter;

  logic       sys_clk = 1'b0;
  logic       rst, bus_sclk_in, bus_cs_n_in, real_bit_in;
  logic       load_valid, load_select, load_ready;
  logic [7:0] load_data;
  logic       bus_bit_out, word_done, underrun, frame_abort;
  logic [3:0] bit_count;

  mitm_out_shifter #(
    .DATA_SIZE  (8),
    .SYNC_STAGES(2),
    .CPOL       (0),
    .MSB_FIRST  (1)
  ) dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .bus_sclk_in(bus_sclk_in),
    .bus_cs_n_in(bus_cs_n_in),
    .real_bit_in(real_bit_in),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_select(load_select),
    .load_ready (load_ready),
    .bus_bit_out(bus_bit_out),
    .bit_count  (bit_count),
    .word_done  (word_done),
    .underrun   (underrun),
    .frame_abort(frame_abort)
  );

  always #5 sys_clk = ~sys_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Pulse counters and passthrough monitor, sampled on the inactive edge.
  int   n_done = 0, n_urun = 0, n_abort = 0, pass_err = 0;
  logic chk_pass = 1'b0;
  always @(negedge sys_clk) begin
    if (word_done === 1'b1)   n_done++;
    if (underrun === 1'b1)    n_urun++;
    if (frame_abort === 1'b1) n_abort++;
    if (chk_pass && (bus_bit_out !== real_bit_in)) pass_err++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       do_load;
    logic [7:0] data;
    logic       sel;
    logic [7:0] real_pat;
    logic [7:0] exp_out;
    int         exp_urun;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change 2 ns after the active edge.
  task automatic tick();
    @(posedge sys_clk);
    #2;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic load(input logic [7:0] d, input logic s);
    int k = 0;
    while (!load_ready && k < 200) begin
      tick();
      k++;
    end
    check("load_ready_wait", {31'd0, load_ready}, 32'd1);
    load_valid  = 1'b1;
    load_data   = d;
    load_select = s;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic cs_low();
    bus_cs_n_in = 1'b0;
    ticks(8);
  endtask

  task automatic cs_high();
    ticks(8);
    bus_cs_n_in = 1'b1;
    ticks(8);
  endtask

  // SCLK = sys_clk/16; far end samples the line just before each leading edge.
  task automatic clock_bits(input logic [7:0] pat, input int n, output logic [7:0] got);
    got = 8'h00;
    for (int i = 0; i < n; i++) begin
      real_bit_in = pat[7-i];
      ticks(8);
      got[7-i]    = bus_bit_out;
      bus_sclk_in = 1'b1;
      ticks(8);
      bus_sclk_in = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] got, got2;
    int u0, d0, a0, p0;

    //             load  data   sel   real   expect urun
    vecs[0] = '{1'b1, 8'hA5, 1'b1, 8'h00, 8'hA5, 0};
    vecs[1] = '{1'b0, 8'h00, 1'b0, 8'h5A, 8'h5A, 1};
    vecs[2] = '{1'b1, 8'hFF, 1'b0, 8'h00, 8'h00, 0};
    vecs[3] = '{1'b1, 8'h0F, 1'b1, 8'hF0, 8'h0F, 0};
    vecs[4] = '{1'b1, 8'h3C, 1'b0, 8'h99, 8'h99, 0};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 8'hC6, 8'hC6, 1};

    rst = 1'b1; bus_sclk_in = 1'b0; bus_cs_n_in = 1'b1; real_bit_in = 1'b0;
    load_valid = 1'b0; load_data = 8'h00; load_select = 1'b0;
    ticks(3);
    rst = 1'b0;
    tick();

    // Reset state.
    check("rst_load_ready", {31'd0, load_ready}, 32'd1);
    check("rst_bit_count", {28'd0, bit_count}, 32'd0);
    check("rst_pulses", {29'd0, word_done, underrun, frame_abort}, 32'd0);
    real_bit_in = 1'b1; #1;
    check("rst_pass_1", {31'd0, bus_bit_out}, 32'd1);
    real_bit_in = 1'b0; #1;
    check("rst_pass_0", {31'd0, bus_bit_out}, 32'd0);

    // Single-word frames from the table.
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].do_load) begin
        load(vecs[i].data, vecs[i].sel);
        check($sformatf("v%0d_ready_low", i), {31'd0, load_ready}, 32'd0);
      end
      u0 = n_urun; d0 = n_done; a0 = n_abort; p0 = pass_err;
      chk_pass = !(vecs[i].do_load && vecs[i].sel);
      cs_low();
      check($sformatf("v%0d_underrun", i), n_urun - u0, vecs[i].exp_urun);
      check($sformatf("v%0d_ready_high", i), {31'd0, load_ready}, 32'd1);
      clock_bits(vecs[i].real_pat, 8, got);
      check($sformatf("v%0d_data", i), {24'd0, got}, {24'd0, vecs[i].exp_out});
      check($sformatf("v%0d_done", i), n_done - d0, 1);
      check($sformatf("v%0d_count", i), {28'd0, bit_count}, 32'd0);
      cs_high();
      chk_pass = 1'b0;
      check($sformatf("v%0d_abort", i), n_abort - a0, 0);
      check($sformatf("v%0d_pass", i), pass_err - p0, 0);
    end

    // Back-to-back words: second word loaded while the first is shifting.
    load(8'h3C, 1'b1);
    u0 = n_urun; d0 = n_done;
    cs_low();
    load(8'hC3, 1'b1);
    clock_bits(8'h00, 8, got);
    check("b2b_underrun", n_urun - u0, 0);
    clock_bits(8'h00, 8, got2);
    check("b2b_word1", {24'd0, got}, 32'h3C);
    check("b2b_word2", {24'd0, got2}, 32'hC3);
    check("b2b_done", n_done - d0, 2);
    cs_high();

    // Frame abort after three leading edges; queued word survives to the next frame.
    load(8'h81, 1'b1);
    cs_low();
    load(8'h96, 1'b1);
    clock_bits(8'h00, 3, got);
    check("abort_bits", {29'd0, got[7:5]}, 32'd4);
    check("abort_count3", {28'd0, bit_count}, 32'd3);
    a0 = n_abort;
    cs_high();
    check("abort_pulse", n_abort - a0, 1);
    check("abort_count0", {28'd0, bit_count}, 32'd0);
    real_bit_in = 1'b1; #1;
    check("abort_pass_1", {31'd0, bus_bit_out}, 32'd1);
    real_bit_in = 1'b0; #1;
    check("abort_pass_0", {31'd0, bus_bit_out}, 32'd0);
    u0 = n_urun;
    cs_low();
    check("abort_next_urun", n_urun - u0, 0);
    clock_bits(8'h00, 8, got);
    check("abort_next_data", {24'd0, got}, 32'h96);
    cs_high();

    // Reset mid-word at bit 4.
    load(8'h55, 1'b1);
    cs_low();
    clock_bits(8'h00, 4, got);
    check("rstmid_bits", {28'd0, got[7:4]}, 32'd5);
    rst = 1'b1;
    bus_cs_n_in = 1'b1;
    ticks(2);
    rst = 1'b0;
    tick();
    check("rstmid_ready", {31'd0, load_ready}, 32'd1);
    check("rstmid_count", {28'd0, bit_count}, 32'd0);
    check("rstmid_pulses", {29'd0, word_done, underrun, frame_abort}, 32'd0);
    real_bit_in = 1'b1; #1;
    check("rstmid_pass_1", {31'd0, bus_bit_out}, 32'd1);
    real_bit_in = 1'b0; #1;
    check("rstmid_pass_0", {31'd0, bus_bit_out}, 32'd0);
    u0 = n_urun;
    cs_low();
    check("rstmid_next_urun", n_urun - u0, 1);
    clock_bits(8'hC3, 8, got);
    check("rstmid_next_data", {24'd0, got}, 32'hC3);
    cs_high();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
